// File: rtl/gray_conv_pkg.sv
// ---------------------------------------------------------------------------
// gray_conv_pkg
// Shared definitions for the gray_conv_arb block: the two-state result FSM
// encoding, the number of requesters and the width of a requester index.
// No ports; imported by the interface, the codec and the top.
// ---------------------------------------------------------------------------
package gray_conv_pkg;

  // Output register occupancy: IDLE holds nothing, FULL holds a result.
  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  // Four requesters share one converter, so an index needs two bits.
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  // The round-robin pointer remembers the last granted requester.  Starting
  // it at the highest index makes requester 0 the first one searched.
  localparam logic [ID_W-1:0] PTR_RESET = ID_W'(NUM_REQ - 1);

endpackage

// File: rtl/gray_conv_arb_if.sv
// ---------------------------------------------------------------------------
// gray_conv_arb_if
// Bundles the requester side and the consumer side of gray_conv_arb.
//   req       : per-requester request (bit i = requester i)
//   din       : packed operands, slice [i*W +: W] belongs to requester i
//   dir       : per-requester direction, 0 = bin->gray, 1 = gray->bin
//   gnt       : one-hot combinational accept strobe
//   out_valid : registered result valid
//   out_id    : requester that owns dout
//   dout      : registered converted code
//   out_ready : consumer accepts dout when out_valid && out_ready
//   cnt       : completed handshakes modulo 2^CNTW
// Modports: master = requesters + consumer (testbench), slave = the block.
// ---------------------------------------------------------------------------
interface gray_conv_arb_if
  import gray_conv_pkg::*;
#(
  parameter int W    = 4,
  parameter int CNTW = 8
);

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] din;
  logic [NUM_REQ-1:0]   dir;
  logic [NUM_REQ-1:0]   gnt;
  logic                 out_valid;
  logic [ID_W-1:0]      out_id;
  logic [W-1:0]         dout;
  logic                 out_ready;
  logic [CNTW-1:0]      cnt;

  // Requesters and the consumer drive the inputs and watch the results.
  modport master (
    output req, din, dir, out_ready,
    input  gnt, out_valid, out_id, dout, cnt
  );

  // The arbiter/converter itself.
  modport slave (
    input  req, din, dir, out_ready,
    output gnt, out_valid, out_id, dout, cnt
  );

endinterface

// File: rtl/gray_codec.sv
// ---------------------------------------------------------------------------
// gray_codec
// Combinational W-bit code converter shared by all requesters.
//   code_i : operand
//   dir_i  : 0 = binary-to-gray, 1 = gray-to-binary
//   code_o : converted code
// Build option: GRAY2BIN_EN.  When it is not defined only the
// binary-to-gray path exists and dir_i is ignored.
// ---------------------------------------------------------------------------
module gray_codec #(
  parameter int W = 4
) (
  input  logic [W-1:0] code_i,
  input  logic         dir_i,
  output logic [W-1:0] code_o
);

  // Binary-to-gray: every bit is the XOR of itself and its upper neighbour;
  // the MSB passes through because the shifted-in bit is zero.
  logic [W-1:0] toGray;
  assign toGray = code_i ^ (code_i >> 1);

`ifdef GRAY2BIN_EN
  // Gray-to-binary: binary bit k is the parity of all gray bits from k up to
  // the MSB.  Writing it as a reduction over a shifted copy avoids a ripple
  // chain that reads its own output inside the block.
  logic [W-1:0] toBinary;

  always_comb begin
    toBinary = '0;
    for (int k = 0; k < W; k++) begin
      toBinary[k] = ^(code_i >> k);
    end
  end

  // Direction picks which conversion reaches the output.
  assign code_o = dir_i ? toBinary : toGray;
`else
  // Direction has no meaning without the gray-to-binary path; it is tied
  // off here so the shared port list stays identical in both builds.
  logic unusedDir;
  assign unusedDir = dir_i;

  assign code_o = toGray;
`endif

endmodule

// File: rtl/gray_conv_arb.sv
// ---------------------------------------------------------------------------
// gray_conv_arb
// Four requesters compete round-robin for one shared gray-code converter.
// The accepted operand is converted and stored in a one-deep output
// register, handed to a consumer with a valid/ready handshake, and every
// completed handshake is counted.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gray_conv_arb_if.slave (req/din/dir/gnt, out_valid/out_id/
//           dout/out_ready, cnt)
// Build option: GRAY2BIN_EN enables the gray-to-binary direction inside
// gray_codec; without it every conversion is binary-to-gray.
// ---------------------------------------------------------------------------
module gray_conv_arb
  import gray_conv_pkg::*;
#(
  parameter int W    = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_conv_arb_if.slave  bus
);

  state_t            state_q,     state_d;
  logic [ID_W-1:0]   lastGrant_q, lastGrant_d;
  logic [ID_W-1:0]   outId_q,     outId_d;
  logic [W-1:0]      dout_q,      dout_d;
  logic [CNTW-1:0]   cnt_q,       cnt_d;

  logic              captureEn;
  logic              capture;
  logic              handshake;
  logic              found;
  logic [ID_W-1:0]   selIdx;
  logic [ID_W-1:0]   candidate;
  logic [NUM_REQ-1:0] grant;
  logic [W-1:0]      codecIn;
  logic              codecDir;
  logic [W-1:0]      codecOut;

  // A new operand may enter when the output register is empty, or when the
  // held result leaves in this same cycle.  Holding reset low also blocks
  // capture so no grant is ever shown during reset.
  assign captureEn = rst_n && ((state_q == IDLE) || bus.out_ready);

  // The consumer takes the held result whenever it is valid and ready.
  assign handshake = (state_q == FULL) && bus.out_ready;

  // Round-robin search starting just above the last granted requester and
  // wrapping around; the first asserted request wins.  The winner's operand
  // and direction are steered to the single shared converter.
  always_comb begin
    found     = 1'b0;
    selIdx    = '0;
    candidate = '0;
    grant     = '0;
    codecIn   = '0;
    codecDir  = 1'b0;

    if (captureEn) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        candidate = lastGrant_q + ID_W'(off);
        if (!found && bus.req[candidate]) begin
          found  = 1'b1;
          selIdx = candidate;
        end
      end
    end

    if (found) begin
      grant[selIdx] = 1'b1;
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (selIdx == ID_W'(i)) begin
        codecIn  = bus.din[i*W +: W];
        codecDir = bus.dir[i];
      end
    end
  end

  assign capture = found;

  // One converter serves every requester; only the selected operand reaches
  // it in any given cycle.
  gray_codec #(
    .W (W)
  ) u_codec (
    .code_i (codecIn),
    .dir_i  (codecDir),
    .code_o (codecOut)
  );

  // Next-state logic for the result FSM, the output register, the arbiter
  // pointer and the handshake counter.  A capture in the FULL state
  // overwrites the result that is leaving in the same cycle, giving one
  // result per cycle under continuous traffic.  The counter wraps silently.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    outId_d     = outId_q;
    dout_d      = dout_q;
    cnt_d       = cnt_q;

    if (handshake) begin
      cnt_d = cnt_q + CNTW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (bus.out_ready && !capture) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      lastGrant_d = selIdx;
      outId_d     = selIdx;
      dout_d      = codecOut;
    end
  end

  // State registers.  Reset empties the output register without counting a
  // handshake and rewinds the pointer so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= PTR_RESET;
      outId_q     <= '0;
      dout_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      outId_q     <= outId_d;
      dout_q      <= dout_d;
      cnt_q       <= cnt_d;
    end
  end

  // Drive the interface outputs; out_valid is simply the FSM state.
  assign bus.gnt       = grant;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_id    = outId_q;
  assign bus.dout      = dout_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_gray_conv_arb.sv
// ---------------------------------------------------------------------------
// tb_gray_conv_arb
// Self-checking bench for gray_conv_arb.  A behavioural model written in
// plain integer arithmetic predicts grants, results and the handshake count
// every cycle; directed steps cover the named scenarios and a randomized
// phase follows.  Honours GRAY2BIN_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_gray_conv_arb;

  localparam int W    = 4;
  localparam int CNTW = 8;

`ifdef GRAY2BIN_EN
  localparam bit G2B_ON = 1'b1;
`else
  localparam bit G2B_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int           mLast;
  bit           mValid;
  int           mId;
  logic [W-1:0] mDout;
  int           mCnt;
  logic [3:0]   lastGnt;

  // Random-phase requester bookkeeping.
  bit           pendReq [4];
  logic [W-1:0] pendDin [4];
  bit           pendDir [4];

  logic [3:0]   rv;
  logic [4*W-1:0] dv;
  logic [3:0]   drv;
  logic [4*W-1:0] tmpDin;

  gray_conv_arb_if #(.W(W), .CNTW(CNTW)) bus ();

  gray_conv_arb #(
    .W    (W),
    .CNTW (CNTW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, asserted, reported on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion using integer XOR arithmetic.
  function automatic logic [W-1:0] refConvert(input logic [W-1:0] v, input bit d);
    int unsigned x;
    int unsigned r;
    x = v;
    if (d && G2B_ON) begin
      r = 0;
      for (int s = 0; s < W; s++) r = r ^ (x >> s);
    end else begin
      r = x ^ (x >> 1);
    end
    return r[W-1:0];
  endfunction

  // Reference arbitration: -1 means no grant this cycle.
  function automatic int refPick(input logic [3:0] r, input bit rdy);
    int idx;
    if (mValid && !rdy) return -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (mLast + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mLast   = 3;
    mValid  = 1'b0;
    mId     = 0;
    mDout   = '0;
    mCnt    = 0;
    lastGnt = 4'b0;
  endtask

  // Drives one cycle of stimulus (entered just after a rising edge), checks
  // the combinational grant mid-cycle, advances the model on the edge and
  // checks the registered outputs just after it.
  task automatic applyStimulus(input logic [3:0] r, input logic [4*W-1:0] d,
                               input logic [3:0] dr, input bit rdy);
    int g;
    logic [3:0] expGnt;
    bus.req       = r;
    bus.din       = d;
    bus.dir       = dr;
    bus.out_ready = rdy;
    @(negedge clk);
    g = refPick(r, rdy);
    expGnt = (g >= 0) ? 4'(1 << g) : 4'b0;
    checkOutput("gnt", 32'(bus.gnt), 32'(expGnt));
    @(posedge clk);
    if (mValid && rdy) mCnt = (mCnt + 1) % (1 << CNTW);
    if (g >= 0) begin
      mValid = 1'b1;
      mId    = g;
      mDout  = refConvert(d[g*W +: W], dr[g]);
      mLast  = g;
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
    #1;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
    if (mValid) begin
      checkOutput("out_id", 32'(bus.out_id), 32'(mId));
      checkOutput("dout", 32'(bus.dout), 32'(mDout));
    end
    checkOutput("cnt", 32'(bus.cnt), 32'(mCnt));
    lastGnt = expGnt;
  endtask

  initial begin
    $display("[TB] start, GRAY2BIN_EN=%0d", G2B_ON);
    modelReset();

    // Reset state, with all requests raised to show gnt stays low.
    rst_n         = 1'b0;
    bus.req       = 4'b1111;
    bus.din       = '0;
    bus.dir       = '0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_cnt", 32'(bus.cnt), 32'd0);
    checkOutput("rst_dout", 32'(bus.dout), 32'd0);
    checkOutput("rst_out_id", 32'(bus.out_id), 32'd0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four requesting: grants rotate 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      tmpDin = 16'($urandom);
      applyStimulus(4'b1111, tmpDin, 4'b0000, 1'b1);
    end
    checkOutput("rr_last_id", 32'(bus.out_id), 32'd0);

    // Single requester 0, operand 0101 -> gray 0111.
    applyStimulus(4'b0001, 16'h0005, 4'b0000, 1'b1);
    checkOutput("dir0_dout", 32'(bus.dout), 32'h7);
    checkOutput("dir0_id", 32'(bus.out_id), 32'd0);
    applyStimulus(4'b0000, 16'h0000, 4'b0000, 1'b1);

    // Result pending with consumer stalled for three cycles, then released.
    applyStimulus(4'b1111, 16'h1234, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 16'h1234, 4'b0000, 1'b0);
    applyStimulus(4'b1111, 16'h1234, 4'b0000, 1'b1);
    applyStimulus(4'b0000, 16'h0000, 4'b0000, 1'b1);

    // Requester 1 with operand 0111 and dir=1.
    applyStimulus(4'b0010, 16'h0070, 4'b0010, 1'b1);
    checkOutput("dir1_dout", 32'(bus.dout), G2B_ON ? 32'h5 : 32'h4);
    checkOutput("dir1_id", 32'(bus.out_id), 32'd1);

    // Asynchronous reset while a result is held.
    applyStimulus(4'b0001, 16'h0003, 4'b0000, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("arst_cnt", 32'(bus.cnt), 32'd0);
    checkOutput("arst_gnt", 32'(bus.gnt), 32'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1111, 16'hABCD, 4'b0000, 1'b1);
    checkOutput("post_rst_id", 32'(bus.out_id), 32'd0);

    // Counter wrap: run to 255 handshakes, then one more.
    for (int i = 0; i < 1000 && mCnt != 255; i++) begin
      tmpDin = 16'($urandom);
      applyStimulus(4'b1111, tmpDin, 4'($urandom), 1'b1);
    end
    checkOutput("cnt_at_255", 32'(bus.cnt), 32'd255);
    applyStimulus(4'b1111, 16'h0F0F, 4'b0000, 1'b1);
    checkOutput("cnt_wrap", 32'(bus.cnt), 32'd0);

    // Randomized traffic: requests persist until granted, may be withdrawn.
    for (int i = 0; i < 4; i++) pendReq[i] = 1'b0;
    lastGnt = 4'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (pendReq[i] && lastGnt[i]) pendReq[i] = 1'b0;
        if (!pendReq[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            pendReq[i] = 1'b1;
            pendDin[i] = W'($urandom);
            pendDir[i] = 1'($urandom_range(0, 1));
          end
        end else if ($urandom_range(0, 7) == 0) begin
          pendReq[i] = 1'b0;
        end
        rv[i]          = pendReq[i];
        dv[i*W +: W]   = pendDin[i];
        drv[i]         = pendDir[i];
      end
      applyStimulus(rv, dv, drv, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
